mem_req_arbiter: RTL and testbench

//  Arbitrates I-cache and D-cache line requests onto one shared memory port.

---
 rtl/mem_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Arbitrates I-cache and D-cache line requests onto one shared memory port through a
// fully registered IDLE -> ISSUE -> RESP handshake. D-side wins by default; a starvation
// counter forces an I grant after STARVE_MAX consecutive D grants while I is waiting.
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, an access that sees no mem_ack
// within TIMEOUT_CYC cycles is abandoned: the owner gets its ready pulse with zeroed read
// data and arb_err pulses. When undefined, ISSUE waits indefinitely and arb_err stays 0.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_wack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  state_e              state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                owner_d_q, owner_d_d;  // 1: D-side owns the current access
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                d_wack_q, d_wack_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                arb_err_q, arb_err_d;
  logic                grant_i;
  logic                timeout;

  // I wins only when D is absent or I has been passed over STARVE_MAX times.
  assign grant_i = i_req && (!d_req || (starve_q == StarveMax));

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic [TmoW-1:0] tmo_q;

  assign timeout = (state_q == StIssue) && (tmo_q == TmoLast);

  // Count cycles spent in ISSUE; restarts from zero for every access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (state_q != StIssue) begin
      tmo_q <= '0;
    end else if (!mem_ack) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output logic for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_d_d   = owner_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    d_wack_d    = 1'b0;
    arb_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          state_d     = StIssue;
          mem_req_d   = 1'b1;
          owner_d_d   = !grant_i;
          mem_we_d    = !grant_i && d_we;
          mem_addr_d  = grant_i ? i_addr : d_addr;
          mem_wdata_d = grant_i ? '0 : d_wdata;
          // Only D grants that leave I waiting count towards starvation.
          if (!grant_i && i_req) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      StIssue: begin
        if (mem_ack) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          if (owner_d_q) begin
            d_ready_d = 1'b1;
            d_wack_d  = mem_we_q;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end else if (timeout) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          arb_err_d = 1'b1;
          if (owner_d_q) begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = '0;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      owner_d_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      d_wack_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      arb_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_d_q   <= owner_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      d_wack_q    <= d_wack_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      arb_err_q   <= arb_err_d;
    end
  end

  assign i_ready   = i_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_wack    = d_wack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign arb_err   = arb_err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: reset checks, a table of single-requester
// transactions, hand-written arbitration/starvation/reset/timeout sequences, and a
// randomized run checked by a transaction-level scoreboard.
module tb_mem_req_arbiter;
  localparam int unsigned ADDR_W      = 26;
  localparam int unsigned DATA_W      = 128;
  localparam int unsigned STARVE_MAX  = 4;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic              clk;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_wack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              arb_err;

  mem_req_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .i_ready  (i_ready),
    .i_rdata  (i_rdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .d_wack   (d_wack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .arb_err  (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Memory responder and scoreboard state
  bit                sb_en;
  bit                mem_auto;
  bit                use_fixed;
  int                ack_delay;
  int                wait_cnt;
  logic [DATA_W-1:0] fixed_data;
  logic [DATA_W-1:0] sent_data;
  bit                ack_sent;
  bit                prev_mem_req;
  bit                own_d;
  bit                own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  int                d_streak;
  logic [DATA_W-1:0] i_rdata_m;
  logic [DATA_W-1:0] d_rdata_m;
  bit                grants[$];  // 1 = D grant, 0 = I grant
  bit                i_pend;
  bit                d_pend;

  task automatic sb_clear();
    prev_mem_req = 1'b0;
    ack_sent     = 1'b0;
    wait_cnt     = 0;
    d_streak     = 0;
    i_rdata_m    = '0;
    d_rdata_m    = '0;
    i_pend       = 1'b0;
    d_pend       = 1'b0;
  endtask

  // One clock: sample at the falling edge, score, then play the memory side.
  task automatic tick();
    bit exp_d;
    @(negedge clk);
    if (sb_en) begin
      if (ack_sent) begin
        if (!own_d) i_rdata_m = sent_data;
        else if (!own_we) d_rdata_m = sent_data;
      end
      check_b("i_ready", i_ready, ack_sent && !own_d);
      check_b("d_ready", d_ready, ack_sent && own_d);
      check_b("d_wack", d_wack, ack_sent && own_d && own_we);
      check_b("arb_err", arb_err, 1'b0);
      check_w("i_rdata", i_rdata, i_rdata_m);
      check_w("d_rdata", d_rdata, d_rdata_m);
      if (mem_req && !prev_mem_req) begin
        exp_d     = !(i_req && (!d_req || d_streak >= int'(STARVE_MAX)));
        own_d     = exp_d;
        own_we    = exp_d && d_we;
        own_addr  = exp_d ? d_addr : i_addr;
        own_wdata = d_wdata;
        grants.push_back(exp_d);
        if (exp_d && i_req) d_streak++;
        else d_streak = 0;
        check_w("grant_addr", DATA_W'(mem_addr), DATA_W'(own_addr));
        check_b("grant_we", mem_we, own_we);
        if (own_we) check_w("grant_wdata", mem_wdata, own_wdata);
      end else if (mem_req) begin
        check_w("hold_addr", DATA_W'(mem_addr), DATA_W'(own_addr));
        check_b("hold_we", mem_we, own_we);
        if (own_we) check_w("hold_wdata", mem_wdata, own_wdata);
      end
    end
    prev_mem_req = mem_req;
    ack_sent = 1'b0;
    if (mem_ack) begin
      mem_ack   = 1'b0;
      mem_rdata = rand_line();
      wait_cnt  = 0;
    end else if (mem_auto && mem_req) begin
      if (wait_cnt >= ack_delay) begin
        sent_data = use_fixed ? fixed_data : rand_line();
        mem_ack   = 1'b1;
        mem_rdata = sent_data;
        ack_sent  = 1'b1;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
        mem_rdata = rand_line();
      end
    end else begin
      wait_cnt  = 0;
      mem_rdata = rand_line();
    end
  endtask

  task automatic raise_i(input logic [ADDR_W-1:0] addr);
    i_req  = 1'b1;
    i_addr = addr;
    i_pend = 1'b1;
  endtask

  task automatic raise_d(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    d_req   = 1'b1;
    d_we    = we;
    d_addr  = addr;
    d_wdata = wdata;
    d_pend  = 1'b1;
  endtask

  // Requester behaviour: hold until ready, drop on the ready pulse, maybe re-raise later.
  task automatic drive_reqs(input int pct_i, input int pct_d);
    if (i_ready) begin
      i_req  = 1'b0;
      i_pend = 1'b0;
    end else if (!i_pend && int'($urandom_range(99)) < pct_i) begin
      raise_i(ADDR_W'($urandom()));
    end
    if (d_ready) begin
      d_req  = 1'b0;
      d_pend = 1'b0;
    end else if (!d_pend && int'($urandom_range(99)) < pct_d) begin
      raise_d(1'($urandom_range(1)), ADDR_W'($urandom()), rand_line());
    end
  endtask

  task automatic drain(input int max_ticks);
    int n = 0;
    while ((i_pend || d_pend) && n < max_ticks) begin
      tick();
      drive_reqs(0, 0);
      n++;
    end
    check_b("drain_done", i_pend || d_pend, 1'b0);
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check_b({tag, "_mem_req"}, mem_req, 1'b0);
    check_b({tag, "_mem_we"}, mem_we, 1'b0);
    check_w({tag, "_mem_addr"}, DATA_W'(mem_addr), '0);
    check_w({tag, "_mem_wdata"}, mem_wdata, '0);
    check_b({tag, "_i_ready"}, i_ready, 1'b0);
    check_b({tag, "_d_ready"}, d_ready, 1'b0);
    check_b({tag, "_d_wack"}, d_wack, 1'b0);
    check_b({tag, "_arb_err"}, arb_err, 1'b0);
    check_w({tag, "_i_rdata"}, i_rdata, '0);
    check_w({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  typedef struct {
    bit                is_d;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                delay;
    logic [DATA_W-1:0] rdata;
    int                exp_lat;
    bit                exp_wack;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    bit got;

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    sb_en = 1'b1; mem_auto = 1'b0; use_fixed = 1'b0; ack_delay = 0; fixed_data = '0;
    sent_data = '0; own_d = 1'b0; own_we = 1'b0; own_addr = '0; own_wdata = '0;
    sb_clear();

    vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 26'h0000040, wdata: '0, delay: 3,
                rdata: {16{8'hA5}}, exp_lat: 5, exp_wack: 1'b0};
    vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 26'h0000123, wdata: 128'h1234, delay: 1,
                rdata: {16{8'h3C}}, exp_lat: 3, exp_wack: 1'b1};
    vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 26'h3FFFFFF, wdata: 128'h5555, delay: 0,
                rdata: {4{32'hDEADBEEF}}, exp_lat: 2, exp_wack: 1'b0};
    vecs[3] = '{is_d: 1'b0, we: 1'b0, addr: 26'h0000000, wdata: '0, delay: 0,
                rdata: {DATA_W{1'b1}}, exp_lat: 2, exp_wack: 1'b0};
    vecs[4] = '{is_d: 1'b1, we: 1'b1, addr: 26'h1555555, wdata: {DATA_W{1'b1}}, delay: 2,
                rdata: {16{8'h77}}, exp_lat: 4, exp_wack: 1'b1};

    // Reset state
    @(negedge clk);
    check_zero_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Table-driven single-requester transactions
    mem_auto  = 1'b1;
    use_fixed = 1'b1;
    foreach (vecs[k]) begin
      ack_delay  = vecs[k].delay;
      fixed_data = vecs[k].rdata;
      if (vecs[k].is_d) raise_d(vecs[k].we, vecs[k].addr, vecs[k].wdata);
      else raise_i(vecs[k].addr);
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
        tick();
        n++;
        got = vecs[k].is_d ? d_ready : i_ready;
      end
      check_i($sformatf("vec%0d_latency", k), n, vecs[k].exp_lat);
      check_b($sformatf("vec%0d_wack", k), d_wack, vecs[k].exp_wack);
      if (!vecs[k].is_d) check_w($sformatf("vec%0d_i_rdata", k), i_rdata, vecs[k].rdata);
      else if (!vecs[k].we) check_w($sformatf("vec%0d_d_rdata", k), d_rdata, vecs[k].rdata);
      i_req = 1'b0; d_req = 1'b0; i_pend = 1'b0; d_pend = 1'b0;
      tick();
    end
    use_fixed = 1'b0;

    // Simultaneous requests with no starvation history: D first, then I
    grants.delete();
    ack_delay = 1;
    raise_i(26'h0000AAA);
    raise_d(1'b0, 26'h0000BBB, '0);
    drain(40);
    check_i("simul_grants", grants.size(), 2);
    if (grants.size() == 2) begin
      check_b("simul_first_d", grants[0], 1'b1);
      check_b("simul_second_i", grants[1], 1'b0);
    end

    // Starvation: both sides keep requesting; pattern is 4 D grants then 1 I grant
    grants.delete();
    ack_delay = 0;
    raise_i(26'h0001111);
    raise_d(1'b1, 26'h0002222, rand_line());
    n = 0;
    while (grants.size() < 10 && n < 200) begin
      tick();
      drive_reqs(100, 100);
      n++;
    end
    check_b("starve_enough_grants", grants.size() >= 10, 1'b1);
    if (grants.size() >= 10) begin
      for (int k = 0; k < 10; k++) begin
        check_b($sformatf("starve_grant%0d", k), grants[k], (k % 5) != 4);
      end
    end
    drain(60);

    // mem_ack outside ISSUE is ignored
    mem_auto = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_ack   = 1'b1;
      mem_rdata = rand_line();
      tick();
      check_b("stray_ack_no_req", mem_req, 1'b0);
    end
    tick();
    check_b("stray_ack_idle", mem_req, 1'b0);

    // Requester drops and changes its inputs during ISSUE: access still completes
    mem_auto  = 1'b1;
    ack_delay = 3;
    raise_d(1'b1, 26'h0003333, rand_line());
    n = 0;
    while (!mem_req && n < 10) begin
      tick();
      n++;
    end
    check_b("drop_issue_started", mem_req, 1'b1);
    d_req = 1'b0; d_we = 1'b0; d_addr = 26'h0004444; d_wdata = rand_line();
    raise_i(26'h0005555);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = d_ready;
    end
    check_b("drop_still_ready", got, 1'b1);
    check_b("drop_wack", d_wack, 1'b1);
    d_pend = 1'b0;
    drain(40);

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: no mem_ack, mem_req held for TIMEOUT_CYC cycles, then error response
    sb_en    = 1'b0;
    mem_auto = 1'b0;
    raise_i(26'h0006666);
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (mem_req) n++;
      else if (n > 0) got = 1'b1;
    end
    check_i("tmo_req_cycles", n, int'(TIMEOUT_CYC));
    check_b("tmo_i_ready", i_ready, 1'b1);
    check_b("tmo_arb_err", arb_err, 1'b1);
    check_b("tmo_d_wack", d_wack, 1'b0);
    check_w("tmo_i_rdata", i_rdata, '0);
    i_req = 1'b0; i_pend = 1'b0;
    tick();
    check_b("tmo_err_pulse", arb_err, 1'b0);
    i_rdata_m    = '0;
    d_streak     = 0;
    prev_mem_req = mem_req;
    sb_en        = 1'b1;
`else
    // Without the timeout feature ISSUE waits for mem_ack indefinitely
    mem_auto = 1'b0;
    raise_d(1'b0, 26'h0006666, '0);
    for (int k = 0; k < 20; k++) tick();
    check_b("no_tmo_still_waiting", mem_req, 1'b1);
    mem_auto  = 1'b1;
    ack_delay = 0;
    drain(20);
`endif

    // Asynchronous reset in the middle of ISSUE
    mem_auto = 1'b0;
    raise_i(26'h0007777);
    n = 0;
    while (!mem_req && n < 10) begin
      tick();
      n++;
    end
    check_b("rst_issue_started", mem_req, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    i_req = 1'b0;
    sb_clear();
    mem_auto   = 1'b1;
    use_fixed  = 1'b1;
    ack_delay  = 0;
    fixed_data = {4{32'hC0FFEE00}};
    raise_d(1'b0, 26'h0000777, '0);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = d_ready;
    end
    check_i("rst_after_latency", n, 2);
    d_req = 1'b0; d_pend = 1'b0;
    tick();
    use_fixed = 1'b0;

    // Randomized traffic against the scoreboard
    for (int t = 0; t < 1500; t++) begin
      if (!mem_req) ack_delay = int'($urandom_range(4));
      tick();
      drive_reqs(30, 60);
    end
    drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
